// File: rtl/seg7_scan_if.sv
// Producer-to-display handshake: one 4-digit BCD word plus decimal points per transfer.
interface seg7_scan_if;
    logic [15:0] in_digits;
    logic [3:0]  in_dp;
    logic        in_valid;
    logic        in_ready;

    modport master (output in_digits, output in_dp, output in_valid, input in_ready);
    modport slave  (input in_digits, input in_dp, input in_valid, output in_ready);
endinterface

// File: rtl/seg7_scan.sv
// 4-digit multiplexed 7-segment driver with shadow buffering, frame-aligned commit,
// guard-band blanking, 15-level brightness and leading-zero blanking.
module seg7_scan #(
    parameter int PRESCALE_BITS = 14
) (
    input  logic        clk,
    input  logic        rst,
    seg7_scan_if.slave  bus,
    input  logic [3:0]  brightness,
    input  logic        lzb_en,
    output logic [7:0]  seg,
    output logic [3:0]  an,
    output logic        frame_start
);

    localparam int CW = PRESCALE_BITS + 2;

    logic [CW-1:0] cnt;
    logic [15:0]   active_digits;
    logic [3:0]    active_dp;
    logic [15:0]   shadow_digits;
    logic [3:0]    shadow_dp;
    logic          shadow_full;

    logic          wrap;
    logic          transfer;
    logic [1:0]    digidx;
    logic [3:0]    phase;
    logic [3:0]    bright_cap;
    logic          lit;
    logic [3:0]    cur_digit;
    logic          cur_dp;
    logic          blank;
    logic [6:0]    glyph;
    logic [7:0]    seg_next;
    logic [3:0]    an_next;

    function automatic logic [6:0] glyph_of(input logic [3:0] d);
        case (d)
            4'd0:    glyph_of = 7'h3F;
            4'd1:    glyph_of = 7'h06;
            4'd2:    glyph_of = 7'h5B;
            4'd3:    glyph_of = 7'h4F;
            4'd4:    glyph_of = 7'h66;
            4'd5:    glyph_of = 7'h6D;
            4'd6:    glyph_of = 7'h7D;
            4'd7:    glyph_of = 7'h07;
            4'd8:    glyph_of = 7'h7F;
            4'd9:    glyph_of = 7'h6F;
            default: glyph_of = 7'h40;
        endcase
    endfunction

    assign wrap         = &cnt;
    assign bus.in_ready = !shadow_full;
    assign transfer     = bus.in_valid && !shadow_full;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latch).
        seg_next   = 8'hFF;
        an_next    = 4'hF;
        blank      = 1'b0;
        digidx     = cnt[PRESCALE_BITS+1:PRESCALE_BITS];
        phase      = cnt[PRESCALE_BITS-1:PRESCALE_BITS-4];
        bright_cap = (brightness == 4'd15) ? 4'd14 : brightness;
        // Phase 0 and 15 stay dark so anode switching never ghosts onto a neighbour.
        lit        = (phase != 4'd0) && (phase <= bright_cap);
        cur_digit  = active_digits[{digidx, 2'b00} +: 4];
        cur_dp     = active_dp[digidx];
        glyph      = glyph_of(cur_digit);

        if (lzb_en) begin
            case (digidx)
                2'd3:    blank = (active_digits[15:12] == 4'd0);
                2'd2:    blank = (active_digits[15:8]  == 8'd0);
                2'd1:    blank = (active_digits[15:4]  == 12'd0);
                default: blank = 1'b0;
            endcase
        end

        // A blanked digit still drives its anode when only its decimal point is lit.
        if (lit && !(blank && !cur_dp)) begin
            an_next  = ~(4'b0001 << digidx);
            seg_next = ~{cur_dp, (blank ? 7'h00 : glyph)};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt           <= '0;
            active_digits <= '0;
            active_dp     <= '0;
            shadow_digits <= '0;
            shadow_dp     <= '0;
            shadow_full   <= 1'b0;
            frame_start   <= 1'b0;
            seg           <= 8'hFF;
            an            <= 4'hF;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            cnt         <= cnt + 1'b1;
            frame_start <= wrap;
            seg         <= seg_next;
            an          <= an_next;
            if (wrap && shadow_full) begin
                active_digits <= shadow_digits;
                active_dp     <= shadow_dp;
                shadow_full   <= 1'b0;
            end else if (transfer) begin
                shadow_digits <= bus.in_digits;
                shadow_dp     <= bus.in_dp;
                shadow_full   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan at PRESCALE_BITS=6 (slot 64 cycles, phase 4 cycles, frame 256).
module tb_seg7_scan;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] brightness = 4'd15;
    logic       lzb_en = 1'b0;
    logic [7:0] seg;
    logic [3:0] an;
    logic       frame_start;

    int total = 0;
    int bad = 0;
    int tcnt = 0;
    int fs_count = 0;
    int lit_count = 0;
    int an3_low = 0;

    seg7_scan_if bus ();

    seg7_scan #(.PRESCALE_BITS(6)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .brightness(brightness),
        .lzb_en(lzb_en),
        .seg(seg),
        .an(an),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; outputs are sampled on the falling edge, tcnt equals the DUT counter.
    task automatic tick();
        @(posedge clk);
        tcnt++;
        @(negedge clk);
        if (frame_start) fs_count++;
        if (an != 4'hF) lit_count++;
        if (an[3] == 1'b0) an3_low++;
    endtask

    task automatic run_to(input int t);
        while (tcnt < t) tick();
    endtask

    task automatic check_out(input string tag, input logic [7:0] s, input logic [3:0] a);
        check({tag, "_seg"}, 32'(seg), 32'(s));
        check({tag, "_an"}, 32'(an), 32'(a));
    endtask

    initial begin
        bus.in_digits = 16'h0000;
        bus.in_dp     = 4'b0000;
        bus.in_valid  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(bus.in_ready), 32'd1);
        rst  = 1'b0;
        tcnt = 0;
        check_out("reset", 8'hFF, 4'hF);
        check("reset_fs", 32'(frame_start), 32'd0);

        // Idle frame, all zeros, full brightness; output lags the counter by one cycle.
        run_to(1);   check_out("ph0_dark", 8'hFF, 4'hF);
        run_to(5);   check_out("d0_ph1", 8'hC0, 4'b1110);
        run_to(60);  check_out("d0_ph14", 8'hC0, 4'b1110);
        run_to(61);  check_out("d0_ph15", 8'hFF, 4'hF);
        run_to(69);  check_out("d1_ph1", 8'hC0, 4'b1101);

        // Word 1234, dp on digit2, sent mid-frame.
        run_to(100);
        bus.in_digits = 16'h1234; bus.in_dp = 4'b0100; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check("ready_drop", 32'(bus.in_ready), 32'd0);
        run_to(133); check_out("old_d2", 8'hC0, 4'b1011);
        run_to(255); check("fs_before", 32'(frame_start), 32'd0);
        run_to(256);
        check("fs_wrap", 32'(frame_start), 32'd1);
        check("ready_back", 32'(bus.in_ready), 32'd1);
        run_to(261); check_out("new_d0", 8'h99, 4'b1110);

        // Next word 9876 fills the shadow; 5678 is then held until the commit frees it.
        run_to(300);
        bus.in_digits = 16'h9876; bus.in_dp = 4'b0000; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        run_to(389); check_out("new_d2_dp", 8'h24, 4'b1011);
        run_to(400);
        bus.in_digits = 16'h5678; bus.in_dp = 4'b0000; bus.in_valid = 1'b1;
        check("held_off", 32'(bus.in_ready), 32'd0);
        run_to(453); check_out("new_d3", 8'hF9, 4'b0111);
        run_to(511); check("fs_once", 32'(fs_count), 32'd1);
        run_to(512); check("ready_commit", 32'(bus.in_ready), 32'd1);
        tick();
        check("accept_5678", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b0;
        run_to(517); check_out("f3_d0", 8'h82, 4'b1110);
        run_to(581); check_out("f3_d1", 8'hF8, 4'b1101);
        run_to(709); check_out("f3_d3", 8'h90, 4'b0111);
        run_to(768); check("ready_f4", 32'(bus.in_ready), 32'd1);
        run_to(773); check_out("f4_d0", 8'h80, 4'b1110);
        run_to(965); check_out("f4_d3", 8'h92, 4'b0111);

        // Leading-zero blanking on 0090.
        run_to(800);
        bus.in_digits = 16'h0090; bus.in_dp = 4'b0000; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        run_to(1024);
        lzb_en  = 1'b1;
        an3_low = 0;
        run_to(1029); check_out("lzb_d0", 8'hC0, 4'b1110);
        run_to(1093); check_out("lzb_d1", 8'h90, 4'b1101);
        run_to(1157); check_out("lzb_d2", 8'hFF, 4'hF);
        run_to(1280); check("lzb_an3", 32'(an3_low), 32'd0);

        // Brightness 3 then 0.
        brightness = 4'd3;
        lit_count  = 0;
        run_to(1293); check_out("br3_ph3", 8'hC0, 4'b1110);
        run_to(1297); check_out("br3_ph4", 8'hFF, 4'hF);
        run_to(1344); check("br3_width", 32'(lit_count), 32'd12);
        run_to(1536);
        brightness = 4'd0;
        lit_count  = 0;
        run_to(1792); check("br0_dark", 32'(lit_count), 32'd0);

        // Reset while lit and with the shadow full.
        brightness = 4'd15;
        run_to(1800);
        bus.in_digits = 16'h4321; bus.in_dp = 4'b1111; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check("shadow_full", 32'(bus.in_ready), 32'd0);
        run_to(1805); check_out("pre_rst", 8'hC0, 4'b1110);
        rst = 1'b1;
        #1;
        check_out("mid_rst", 8'hFF, 4'hF);
        check("mid_rst_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst    = 1'b0;
        lzb_en = 1'b0;
        tcnt   = 0;
        run_to(5);   check_out("post_d0", 8'hC0, 4'b1110);
        run_to(197); check_out("post_d3", 8'hC0, 4'b0111);
        run_to(453); check_out("discard_d3", 8'hC0, 4'b0111);
        check("post_ready", 32'(bus.in_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg7_scan.md
Name: seg7_scan

Overview:
- 4-digit multiplexed 7-segment display driver that sits downstream of the BCD digit counter and drives the board's seg/an pins.
- Accepts a 4-digit BCD word plus decimal points over a valid/ready handshake and buffers it in a shadow register.
- Commits the buffered word only at a frame boundary, so a displayed frame never mixes old and new digits.
- Adds guard-band blanking, 15-level brightness and optional leading-zero blanking.

Parameters:
- PRESCALE_BITS, 14, log2 of clock cycles per digit slot (must be >= 4).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- in_digits  input  16  BCD digits; [3:0]=digit0 (rightmost, an[0]) ... [15:12]=digit3
- in_dp  input  4  decimal point per digit, 1=lit; bit i belongs to digit i
- in_valid  input  1  in_digits/in_dp valid
- in_ready  output  1  shadow register empty; a transfer occurs when in_valid && in_ready
- brightness  input  4  0=display off, 14 or 15=maximum
- lzb_en  input  1  leading-zero blanking enable
- seg  output  8  active-low segments {DP,G,F,E,D,C,B,A}
- an  output  4  active-low digit enables
- frame_start  output  1  one-cycle pulse when a new frame begins

Behaviour:
- Reset (async, immediate):
  - scan counter = 0, active digits = 0, active dp = 0, shadow_full = 0, frame_start = 0.
  - seg = 8'hFF, an = 4'hF; in_ready = 1 while rst is high.
- Scan counter:
  - Width PRESCALE_BITS+2; increments every cycle and wraps all-ones -> 0.
  - digidx = cnt[PRESCALE_BITS+1:PRESCALE_BITS].
  - phase = cnt[PRESCALE_BITS-1:PRESCALE_BITS-4].
  - Frame = 4 slots = 2^(PRESCALE_BITS+2) cycles.
- Lit condition: 1 <= phase <= min(brightness,14). Phases 0 and 15 are always dark (anode-switch guard band).
- Outputs: seg and an are registered, one cycle after the counter value they are decoded from.
- When lit:
  - an = ~(1<<digidx).
  - seg = ~{dp[digidx], glyph(digit[digidx])}.
- When not lit, or when the digit is blanked: seg = 8'hFF, an = 4'hF.
- Glyph table (GFEDCBA):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Values 10..15 display a dash, 40.
- Leading-zero blanking (lzb_en=1), evaluated on the active register:
  - digit3 is blanked if it is 0.
  - digit2 is blanked if digit3 and digit2 are both 0.
  - digit1 is blanked if digits 3..1 are all 0.
  - digit0 is never blanked.
  - A blanked digit's DP still lights if its dp bit is set; its segments GFEDCBA stay off and its anode is still driven.
- Handshake:
  - in_ready = !shadow_full (combinational from the flag).
  - On a transfer: shadow <= {in_dp,in_digits}, shadow_full <= 1.
  - in_valid while shadow_full=1 is held off; the producer must keep its data stable until accepted.
- Commit:
  - On the cycle cnt == all-ones, if shadow_full: active <= shadow, shadow_full <= 0.
  - frame_start is registered 1 on that same edge, whether or not a commit occurs, so it is high while cnt == 0.
- Simultaneous events:
  - A transfer on the commit cycle cannot happen, because in_ready=0 whenever a commit is pending.
  - If shadow_full=0 on the commit cycle and a transfer occurs, the data goes to shadow only. It is committed at the next frame boundary; there is no bypass.
- brightness and lzb_en are sampled every cycle (no buffering).
- Reset mid-frame: all state returns to reset values. Any pending shadow data is discarded.

Test Plan (PRESCALE_BITS=6: slot = 64 cycles, phase step = 4 cycles, frame = 256):
- Reset, then idle, brightness=15, lzb_en=0:
  - In the digit0 slot at phase 1..14: an=4'b1110, seg=~8'h3F.
  - At phases 0 and 15: seg=8'hFF, an=4'hF.
- Send in_digits=16'h1234, in_dp=4'b0100 mid-frame:
  - in_ready drops the next cycle.
  - The display shows the old value until the wrap.
  - Next frame: the digit0 slot shows seg=~8'h66; the digit2 slot shows seg=~8'hDB (DP plus glyph 2).
  - frame_start pulses once; in_ready returns to 1.
- Shadow full, second word 16'h5678 held valid:
  - Not accepted until the commit frees the shadow.
  - Accepted on the first cycle with in_ready=1, then committed one frame later.
  - No frame shows mixed digits.
- lzb_en=1, digits 16'h0090:
  - an[3] is never low.
  - The digit1 slot shows 6F.
  - The digit0 slot shows 3F (digit0 is not blanked).
- brightness=3:
  - Each slot is lit for exactly phases 1..3 = 12 cycles.
  - brightness=0 keeps an=4'hF for a whole frame.
- Assert rst while seg is lit and the shadow is full:
  - seg=8'hFF, an=4'hF and in_ready=1 immediately.
  - After release, the display shows 0 (reset value).
